csr_exec_ctrl: RTL and testbench
================================

// Module: csr_exec_ctrl
// PURPOSE
//  Initiator side of the CSR file port. Accepts one SYSTEM-opcode instruction at a time from decode,
//  sequences the CSR read / read-modify-write, raises the ecall strobe and returns the rd writeback
//  plus a PC redirect (ecall -> mtvec, mret -> mepc) to the core. Sits between IDU/EXU and the CSR file.
// PARAMETERS
//  XLEN      32   data width; only 32 is supported
//  ADDR_W    12   CSR address width
// PORTS
//  clk             in   1   clock; single clock domain
//  rst             in   1   synchronous, active-high reset
//  in_valid        in   1   instruction offered
//  in_ready        out  1   block idle, can accept
//  inst            in   32  instruction word (opcode 7'h73)
//  pc              in   32  PC of inst
//  rs1_data        in   32  GPR[rs1] value
//  csr_addr        out  12  CSR address to CSR file
//  csr_wdata       out  32  CSR write data
//  csr_wen         out  1   CSR write strobe, 1 cycle
//  csr_rdata       in   32  CSR read data (combinational on csr_addr)
//  csr_ecall       out  1   ecall strobe; CSR file saves pc->mepc, 8->mcause
//  csr_pc          out  32  PC presented with csr_ecall
//  csr_mtvec       in   32  current mtvec
//  csr_mepc        in   32  current mepc
//  out_valid       out  1   result available
//  out_ready       in   1   consumer takes result
//  rd_addr         out  5   GPR destination
//  rd_wdata        out  32  old CSR value
//  rd_wen          out  1   GPR write required
//  redirect_valid  out  1   redirect_pc must be taken
//  redirect_pc     out  32  next PC
//  illegal         out  1   unsupported funct3 / CSR address
// BEHAVIOUR
//  Reset: state IDLE. in_ready=1; every other output is 0. Reset in any state aborts the op with no
//   CSR write and no ecall.
//  Handshake: accept when in_valid&in_ready. inst, pc and rs1_data are latched at accept. in_ready=1 only
//   in IDLE. In RESP all result outputs stay stable until out_valid&out_ready, then go to IDLE.
//  FSM: IDLE -> READ -> WRITE -> RESP for CSRRW/S/C and their I-variants (funct3 1,2,3,5,6,7).
//   IDLE -> TRAP -> RESP for ecall (inst==32'h00000073).
//   IDLE -> RESP for mret (32'h30200073) and illegal.
//  READ: csr_addr=inst[31:20]; old=csr_rdata is captured at the end of the cycle.
//  WRITE: csr_wen=1 for exactly 1 cycle; csr_addr is held.
//   csr_wdata: RW=src; RS=old|src; RC=old&~src. src=rs1_data, or zext(inst[19:15]) for the I-variants.
//   RS/RC with inst[19:15]==0 do not write (csr_wen stays 0); the WRITE cycle is still spent.
//  TRAP: csr_ecall=1 for 1 cycle, csr_pc=latched pc. redirect_pc=csr_mtvec is sampled in the same cycle.
//  Latency from accept edge to out_valid: CSR op 3 cycles, ecall 2, mret/illegal 1.
//  RESP outputs:
//   rd_wdata=old; rd_wen=(rd!=0) for CSR ops, 0 otherwise.
//   redirect_valid=1 for ecall/mret.
//   mret: redirect_pc=csr_mepc, sampled at accept.
//  Illegal: CSR address not in {300,305,341,342}, funct3 0 other than ecall/mret, or funct3 4.
//   Response: illegal=1, rd_wen=0, no csr_wen, no csr_ecall.
//  csr_wen and csr_ecall are never high together. csr_addr is 0 outside READ/WRITE.
// STRUCTURE
//  Shared package csr_pkg:
//   OPC_SYSTEM, funct3 codes, CSR address constants (MSTATUS/MTVEC/MEPC/MCAUSE), ECALL/MRET encodings,
//   FSM state typedef.
//  One sub-module: csr_alu (combinational old/src/funct3 -> wdata, write-enable).
//  FSM, latches and output registers stay in this module.
// TESTING
//  csrrw x5,mtvec, rs1_data=0x80000100, csr_rdata=0 -> WRITE cycle: wen=1, addr=305, wdata=0x80000100;
//   RESP: rd_addr=5, rd_wdata=0, rd_wen=1, 3 cycles.
//  csrrs x0,mstatus,x0 with csr_rdata=0x1800 -> no csr_wen, rd_wen=0, out_valid at cycle 3.
//  csrrci x6,mstatus,8 with old=0x188 -> wdata=0x180, rd_wdata=0x188.
//  ecall at pc=0x80000010, mtvec=0x80000200 -> csr_ecall=1 for 1 cycle with csr_pc=0x80000010;
//   RESP: redirect_pc=0x80000200, redirect_valid=1.
//  mret with mepc=0x80000014, out_ready held low 4 cycles -> outputs stable, in_ready=0,
//   then IDLE after handshake.
//  csrrw to addr 0xF14 -> illegal=1, no csr_wen; rst asserted in WRITE -> wen=0, IDLE next cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR execution controller: encodings, CSR map,
// FSM state type and instruction classification helpers.
package csr_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 12;

  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // funct3 values that never describe a CSR access
  localparam logic [2:0] F3_PRIV = 3'd0;
  localparam logic [2:0] F3_RSVD = 3'd4;

  // Low two funct3 bits select the operation; bit 2 selects the immediate source
  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  localparam logic [ADDR_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [ADDR_W-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [ADDR_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [ADDR_W-1:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] INST_ECALL = 32'h0000_0073;
  localparam logic [XLEN-1:0] INST_MRET  = 32'h3020_0073;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_TRAP  = 3'd3,
    ST_RESP  = 3'd4
  } csr_state_e;

  typedef enum logic [1:0] {
    OP_CSR     = 2'd0,
    OP_ECALL   = 2'd1,
    OP_MRET    = 2'd2,
    OP_ILLEGAL = 2'd3
  } csr_op_e;

  function automatic logic csr_addr_ok(input logic [ADDR_W-1:0] a);
    return (a == CSR_MSTATUS) || (a == CSR_MTVEC) ||
           (a == CSR_MEPC)    || (a == CSR_MCAUSE);
  endfunction

  // ecall/mret are matched on the full word before any field decode
  function automatic csr_op_e classify_inst(input logic [XLEN-1:0] i);
    csr_op_e k;
    if (i == INST_ECALL) begin
      k = OP_ECALL;
    end else if (i == INST_MRET) begin
      k = OP_MRET;
    end else if ((i[6:0] != OPC_SYSTEM) || (i[14:12] == F3_PRIV) ||
                 (i[14:12] == F3_RSVD) || !csr_addr_ok(i[31:20])) begin
      k = OP_ILLEGAL;
    end else begin
      k = OP_CSR;
    end
    return k;
  endfunction

endpackage

// File: rtl/csr_exec_ctrl_if.sv
// Bundle of decode-side, CSR-file-side and writeback-side signals of the
// CSR execution controller.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is raised the payload is held stable until that
// edge; ready may be raised or lowered freely and never depends on valid.
interface csr_exec_ctrl_if;
  import csr_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       inst;
  logic [XLEN-1:0]       pc;
  logic [XLEN-1:0]       rs1_data;

  logic [ADDR_W-1:0]     csr_addr;
  logic [XLEN-1:0]       csr_wdata;
  logic                  csr_wen;
  logic [XLEN-1:0]       csr_rdata;
  logic                  csr_ecall;
  logic [XLEN-1:0]       csr_pc;
  logic [XLEN-1:0]       csr_mtvec;
  logic [XLEN-1:0]       csr_mepc;

  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            rd_addr;
  logic [XLEN-1:0]       rd_wdata;
  logic                  rd_wen;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic                  illegal;

  csr_state_e            dbg_state;

  // Core / CSR-file environment side
  modport master (
    output in_valid, inst, pc, rs1_data, csr_rdata, csr_mtvec, csr_mepc, out_ready,
    input  in_ready, csr_addr, csr_wdata, csr_wen, csr_ecall, csr_pc, out_valid,
           rd_addr, rd_wdata, rd_wen, redirect_valid, redirect_pc, illegal, dbg_state
  );

  // Controller side
  modport slave (
    input  in_valid, inst, pc, rs1_data, csr_rdata, csr_mtvec, csr_mepc, out_ready,
    output in_ready, csr_addr, csr_wdata, csr_wen, csr_ecall, csr_pc, out_valid,
           rd_addr, rd_wdata, rd_wen, redirect_valid, redirect_pc, illegal, dbg_state
  );

endinterface

// File: rtl/csr_alu.sv
// Read-modify-write datapath: combines the old CSR value with the source
// operand according to funct3 and decides whether the write happens at all.
module csr_alu
  import csr_pkg::*;
(
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [4:0]      uimm,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] wdata,
  output logic            we
);

  logic [XLEN-1:0] src;

  // Pick the operand, then apply write / set / clear; set and clear with a zero rs1 field are reads only
  always_comb begin
    src   = funct3[2] ? {{(XLEN-5){1'b0}}, uimm} : rs1_val;
    wdata = '0;
    we    = 1'b0;
    case (funct3[1:0])
      CSR_OP_RW: begin
        wdata = src;
        we    = 1'b1;
      end
      CSR_OP_RS: begin
        wdata = old_val | src;
        we    = (uimm != 5'd0);
      end
      CSR_OP_RC: begin
        wdata = old_val & ~src;
        we    = (uimm != 5'd0);
      end
      default: begin
        wdata = '0;
        we    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_exec_ctrl.sv
// CSR execution controller: accepts one SYSTEM instruction, sequences the
// CSR read / read-modify-write or the ecall strobe, and returns the rd
// writeback and PC redirect to the core.
module csr_exec_ctrl
  import csr_pkg::*;
(
  input logic            clk,
  input logic            rst,
  csr_exec_ctrl_if.slave bus
);

  csr_state_e        state_q, state_d;
  csr_op_e           kind_q, kind_d;
  csr_op_e           in_kind;
  logic [XLEN-1:7]   inst_q, inst_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic [XLEN-1:0]   redir_q, redir_d;

  logic [XLEN-1:0]   alu_wdata;
  logic              alu_we;
  logic              in_resp;
  logic              csr_phase;

  csr_alu u_alu (
    .old_val (old_q),
    .rs1_val (rs1_q),
    .uimm    (inst_q[19:15]),
    .funct3  (inst_q[14:12]),
    .wdata   (alu_wdata),
    .we      (alu_we)
  );

  // Next state, operand latching at accept, old value capture and redirect target sampling
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    old_d   = old_q;
    redir_d = redir_q;
    in_kind = classify_inst(bus.inst);
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          kind_d  = in_kind;
          inst_d  = bus.inst[XLEN-1:7];
          pc_d    = bus.pc;
          rs1_d   = bus.rs1_data;
          old_d   = '0;
          redir_d = (in_kind == OP_MRET) ? bus.csr_mepc : '0;
          case (in_kind)
            OP_CSR:   state_d = ST_READ;
            OP_ECALL: state_d = ST_TRAP;
            default:  state_d = ST_RESP;
          endcase
        end
      end
      ST_READ: begin
        old_d   = bus.csr_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_TRAP: begin
        redir_d = bus.csr_mtvec;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched operands; reset abandons any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kind_q  <= OP_CSR;
      inst_q  <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      old_q   <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      old_q   <= old_d;
      redir_q <= redir_d;
    end
  end

  assign in_resp   = (state_q == ST_RESP);
  assign csr_phase = (state_q == ST_READ) || (state_q == ST_WRITE);

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.csr_addr  = csr_phase ? inst_q[31:20] : '0;
  assign bus.csr_wdata = (state_q == ST_WRITE) ? alu_wdata : '0;
  // Strobes are masked by rst so a reset landing on WRITE/TRAP has no side effect
  assign bus.csr_wen   = (state_q == ST_WRITE) && alu_we && !rst;
  assign bus.csr_ecall = (state_q == ST_TRAP) && !rst;
  assign bus.csr_pc    = (state_q == ST_TRAP) ? pc_q : '0;

  // Result fields come straight from flops that do not move while in RESP
  assign bus.out_valid      = in_resp;
  assign bus.rd_addr        = (in_resp && (kind_q == OP_CSR)) ? inst_q[11:7] : '0;
  assign bus.rd_wdata       = in_resp ? old_q : '0;
  assign bus.rd_wen         = in_resp && (kind_q == OP_CSR) && (inst_q[11:7] != 5'd0);
  assign bus.redirect_valid = in_resp && ((kind_q == OP_ECALL) || (kind_q == OP_MRET));
  assign bus.redirect_pc    = in_resp ? redir_q : '0;
  assign bus.illegal        = in_resp && (kind_q == OP_ILLEGAL);

  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_csr_exec_ctrl.sv
// Self-checking bench for csr_exec_ctrl: directed cases from the block's
// behaviour description plus a randomized sequence against a reference model.
module tb_csr_exec_ctrl;

  logic clk;
  logic rst;

  csr_exec_ctrl_if ifc ();

  csr_exec_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- CSR file environment ----------------
  logic [31:0] r_mstatus, r_mtvec, r_mepc, r_mcause;

  assign ifc.csr_rdata = (ifc.csr_addr == 12'h300) ? r_mstatus :
                         (ifc.csr_addr == 12'h305) ? r_mtvec   :
                         (ifc.csr_addr == 12'h341) ? r_mepc    :
                         (ifc.csr_addr == 12'h342) ? r_mcause  : 32'h0;
  assign ifc.csr_mtvec = r_mtvec;
  assign ifc.csr_mepc  = r_mepc;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [43:0] exp_q[$];
  logic [43:0] got_q[$];

  typedef struct {
    int          lat;
    int          wen_cnt;
    int          wen_cyc;
    logic [43:0] w;
    int          ecall_cnt;
    logic [31:0] ecall_pc;
    logic [11:0] addr_c1;
    logic [11:0] addr_resp;
    logic [71:0] res;
    int          both_hi;
    int          busy_bad;
    int          stable_bad;
    logic        idle_after;
    logic        ready_at_offer;
    logic        got;
  } obs_t;

  typedef struct {
    int          lat;
    int          wen_cnt;
    logic [43:0] w;
    int          ecall_cnt;
    logic [31:0] ecall_pc;
    logic [11:0] addr_c1;
    logic [71:0] res;
  } exp_t;

  function automatic logic [71:0] res_now();
    return {ifc.rd_addr, ifc.rd_wdata, ifc.rd_wen, ifc.redirect_valid,
            ifc.redirect_pc, ifc.illegal};
  endfunction

  function automatic logic [31:0] csr_val(input logic [11:0] a);
    case (a)
      12'h300: return r_mstatus;
      12'h305: return r_mtvec;
      12'h341: return r_mepc;
      default: return r_mcause;
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r);
    exp_t        e;
    logic [11:0] a;
    logic [2:0]  f3;
    logic [4:0]  z;
    logic [4:0]  rd;
    logic [31:0] old, src, nv;
    int          op;
    e  = '{default: 0};
    a  = i[31:20];
    z  = i[19:15];
    f3 = i[14:12];
    rd = i[11:7];
    if (i == 32'h0000_0073) begin
      e.lat = 2;
      e.ecall_cnt = 1;
      e.ecall_pc = p;
      e.res = {5'd0, 32'd0, 1'b0, 1'b1, r_mtvec, 1'b0};
    end else if (i == 32'h3020_0073) begin
      e.lat = 1;
      e.res = {5'd0, 32'd0, 1'b0, 1'b1, r_mepc, 1'b0};
    end else if ((i[6:0] != 7'h73) || (f3 == 3'd0) || (f3 == 3'd4) ||
                 !((a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342))) begin
      e.lat = 1;
      e.res = {5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1};
    end else begin
      old = csr_val(a);
      src = (f3 >= 3'd5) ? {27'd0, z} : r;
      op  = int'(f3) % 4;
      if (op == 1)      nv = src;
      else if (op == 2) nv = old | src;
      else              nv = old & ~src;
      e.lat = 3;
      e.addr_c1 = a;
      if ((op == 1) || (z != 5'd0)) begin
        e.wen_cnt = 1;
        e.w = {a, nv};
      end
      e.res = {rd, old, (rd != 5'd0), 1'b0, 32'd0, 1'b0};
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Offers one instruction, watches every cycle until the response, holds
  // out_ready low for 'hold' cycles, then completes the handshake.
  task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r,
                       input int hold, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    o.ready_at_offer = ifc.in_ready;
    ifc.in_valid = 1'b1;
    ifc.inst     = i;
    ifc.pc       = p;
    ifc.rs1_data = r;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.inst     = $urandom;
    ifc.pc       = $urandom;
    ifc.rs1_data = $urandom;
    for (int c = 1; (c <= 16) && !o.got; c++) begin
      @(negedge clk);
      if (ifc.csr_wen) begin
        o.wen_cnt++;
        o.wen_cyc = c;
        o.w = {ifc.csr_addr, ifc.csr_wdata};
        got_q.push_back({ifc.csr_addr, ifc.csr_wdata});
      end
      if (ifc.csr_ecall) begin
        o.ecall_cnt++;
        o.ecall_pc = ifc.csr_pc;
      end
      if (ifc.csr_wen && ifc.csr_ecall) o.both_hi++;
      if (ifc.in_ready) o.busy_bad++;
      if (c == 1) o.addr_c1 = ifc.csr_addr;
      if (ifc.out_valid) begin
        o.got = 1'b1;
        o.lat = c;
        o.res = res_now();
        o.addr_resp = ifc.csr_addr;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if ((res_now() !== o.res) || !ifc.out_valid || ifc.in_ready) o.stable_bad++;
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    o.idle_after = ifc.in_ready && !ifc.out_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [144:0] data_outs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    data_outs = {ifc.csr_addr, ifc.csr_wdata, ifc.csr_pc, ifc.rd_addr, ifc.rd_wdata, ifc.redirect_pc};
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", ifc.in_ready);
    end
    checks++;
    if ({ifc.out_valid, ifc.csr_wen, ifc.csr_ecall, ifc.rd_wen, ifc.redirect_valid, ifc.illegal} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000",
               {ifc.out_valid, ifc.csr_wen, ifc.csr_ecall, ifc.rd_wen, ifc.redirect_valid, ifc.illegal});
    end
    checks++;
    if (data_outs !== '0) begin
      errors++;
      $display("FAIL reset_data_outputs: got %h, required 0", data_outs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_csrrw();
    obs_t o;
    r_mtvec = 32'h0;
    issue({12'h305, 5'd10, 3'b001, 5'd5, 7'h73}, 32'h8000_0000, 32'h8000_0100, 0, o);
    checks++;
    if (o.lat !== 3) begin errors++; $display("FAIL csrrw_latency: got %0d, required 3", o.lat); end
    checks++;
    if ((o.wen_cnt !== 1) || (o.wen_cyc !== 2)) begin
      errors++;
      $display("FAIL csrrw_wen_pulse: got count %0d at cycle %0d, required count 1 at cycle 2", o.wen_cnt, o.wen_cyc);
    end
    checks++;
    if (o.w !== {12'h305, 32'h8000_0100}) begin
      errors++;
      $display("FAIL csrrw_write: got %h, required %h", o.w, {12'h305, 32'h8000_0100});
    end
    checks++;
    if (o.res !== {5'd5, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL csrrw_result: got %h, required %h", o.res, {5'd5, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0});
    end
    checks++;
    if ((o.addr_c1 !== 12'h305) || (o.addr_resp !== 12'h0)) begin
      errors++;
      $display("FAIL csrrw_csr_addr: got read %h resp %h, required read 305 resp 000", o.addr_c1, o.addr_resp);
    end
    checks++;
    if (o.idle_after !== 1'b1) begin errors++; $display("FAIL csrrw_idle_after: got %b, required 1", o.idle_after); end
  endtask

  task automatic test_csrrs_x0();
    obs_t o;
    r_mstatus = 32'h0000_1800;
    issue({12'h300, 5'd0, 3'b010, 5'd0, 7'h73}, 32'h8000_0004, $urandom, 0, o);
    checks++;
    if ((o.lat !== 3) || (o.wen_cnt !== 0)) begin
      errors++;
      $display("FAIL csrrs_x0_timing: got latency %0d writes %0d, required latency 3 writes 0", o.lat, o.wen_cnt);
    end
    checks++;
    if (o.res !== {5'd0, 32'h1800, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL csrrs_x0_result: got %h, required %h", o.res, {5'd0, 32'h1800, 1'b0, 1'b0, 32'h0, 1'b0});
    end
  endtask

  task automatic test_csrrci();
    obs_t o;
    r_mstatus = 32'h0000_0188;
    issue({12'h300, 5'd8, 3'b111, 5'd6, 7'h73}, 32'h8000_0008, $urandom, 1, o);
    checks++;
    if ((o.wen_cnt !== 1) || (o.w !== {12'h300, 32'h180})) begin
      errors++;
      $display("FAIL csrrci_write: got count %0d value %h, required count 1 value %h", o.wen_cnt, o.w, {12'h300, 32'h180});
    end
    checks++;
    if (o.res !== {5'd6, 32'h188, 1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL csrrci_result: got %h, required %h", o.res, {5'd6, 32'h188, 1'b1, 1'b0, 32'h0, 1'b0});
    end
  endtask

  task automatic test_ecall();
    obs_t o;
    r_mtvec = 32'h8000_0200;
    issue(32'h0000_0073, 32'h8000_0010, $urandom, 0, o);
    checks++;
    if ((o.ecall_cnt !== 1) || (o.ecall_pc !== 32'h8000_0010) || (o.wen_cnt !== 0) || (o.both_hi !== 0)) begin
      errors++;
      $display("FAIL ecall_strobe: got ecalls %0d pc %h writes %0d, required ecalls 1 pc 80000010 writes 0",
               o.ecall_cnt, o.ecall_pc, o.wen_cnt);
    end
    checks++;
    if (o.lat !== 2) begin errors++; $display("FAIL ecall_latency: got %0d, required 2", o.lat); end
    checks++;
    if (o.res !== {5'd0, 32'h0, 1'b0, 1'b1, 32'h8000_0200, 1'b0}) begin
      errors++;
      $display("FAIL ecall_result: got %h, required %h", o.res, {5'd0, 32'h0, 1'b0, 1'b1, 32'h8000_0200, 1'b0});
    end
  endtask

  task automatic test_mret_hold();
    obs_t o;
    r_mepc = 32'h8000_0014;
    issue(32'h3020_0073, 32'h8000_0020, $urandom, 4, o);
    checks++;
    if (o.lat !== 1) begin errors++; $display("FAIL mret_latency: got %0d, required 1", o.lat); end
    checks++;
    if (o.res !== {5'd0, 32'h0, 1'b0, 1'b1, 32'h8000_0014, 1'b0}) begin
      errors++;
      $display("FAIL mret_result: got %h, required %h", o.res, {5'd0, 32'h0, 1'b0, 1'b1, 32'h8000_0014, 1'b0});
    end
    checks++;
    if ((o.stable_bad !== 0) || (o.busy_bad !== 0)) begin
      errors++;
      $display("FAIL mret_hold_stable: got %0d unstable and %0d ready cycles, required 0 and 0", o.stable_bad, o.busy_bad);
    end
    checks++;
    if (o.idle_after !== 1'b1) begin errors++; $display("FAIL mret_idle_after: got %b, required 1", o.idle_after); end
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [31:0] ill [3];
    ill[0] = {12'hF14, 5'd10, 3'b001, 5'd5, 7'h73};
    ill[1] = {12'h300, 5'd3, 3'b100, 5'd7, 7'h73};
    ill[2] = 32'h1050_0073;
    for (int k = 0; k < 3; k++) begin
      issue(ill[k], 32'h8000_0100, 32'hFFFF_FFFF, 0, o);
      checks++;
      if ((o.lat !== 1) || (o.res !== {5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1}) ||
          (o.wen_cnt !== 0) || (o.ecall_cnt !== 0)) begin
        errors++;
        $display("FAIL illegal_%0d: got latency %0d result %h writes %0d ecalls %0d, required latency 1 result %h writes 0 ecalls 0",
                 k, o.lat, o.res, o.wen_cnt, o.ecall_cnt, {5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1});
      end
    end
  endtask

  task automatic test_reset_in_write();
    int stray;
    stray = 0;
    r_mtvec = 32'h0;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.inst     = {12'h305, 5'd10, 3'b001, 5'd5, 7'h73};
    ifc.pc       = 32'h8000_0030;
    ifc.rs1_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.csr_wen !== 1'b0) begin errors++; $display("FAIL rst_in_write_wen: got %b, required 0", ifc.csr_wen); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ((ifc.in_ready !== 1'b1) || (ifc.out_valid !== 1'b0)) begin
      errors++;
      $display("FAIL rst_in_write_idle: got in_ready %b out_valid %b, required 1 0", ifc.in_ready, ifc.out_valid);
    end
    repeat (3) begin
      @(negedge clk);
      if (ifc.csr_wen || ifc.out_valid || ifc.csr_ecall) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL rst_in_write_quiet: got %0d active cycles, required 0", stray); end
  endtask

  task automatic test_back_to_back();
    obs_t        o;
    exp_t        e;
    logic [31:0] i, p, r;
    logic [11:0] a;
    logic [4:0]  z, rd;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [11:0] addr_pool [4];
    logic [43:0] ew, gw;
    addr_pool[0] = 12'h300;
    addr_pool[1] = 12'h305;
    addr_pool[2] = 12'h341;
    addr_pool[3] = 12'h342;
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 80; n++) begin
      r_mstatus = $urandom;
      r_mtvec   = $urandom;
      r_mepc    = $urandom;
      r_mcause  = $urandom;
      p = $urandom;
      r = $urandom;
      case ($urandom_range(0, 9))
        0: i = 32'h0000_0073;
        1: i = 32'h3020_0073;
        default: begin
          f3  = 3'($urandom_range(0, 7));
          a   = ($urandom_range(0, 4) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 3)];
          z   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
          rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
          opc = ($urandom_range(0, 15) == 0) ? 7'h33 : 7'h73;
          i   = {a, z, f3, rd, opc};
        end
      endcase
      e = model(i, p, r);
      if (e.wen_cnt == 1) exp_q.push_back(e.w);
      issue(i, p, r, $urandom_range(0, 3), o);
      checks++;
      if ((o.lat !== e.lat) || (o.res !== e.res)) begin
        errors++;
        $display("FAIL rand_%0d_result: inst %h got latency %0d result %h, required latency %0d result %h",
                 n, i, o.lat, o.res, e.lat, e.res);
      end
      checks++;
      if ((o.ecall_cnt !== e.ecall_cnt) || (o.ecall_pc !== e.ecall_pc) || (o.wen_cnt !== e.wen_cnt) ||
          (o.addr_c1 !== e.addr_c1) || (o.addr_resp !== 12'h0)) begin
        errors++;
        $display("FAIL rand_%0d_csr_side: inst %h got ecalls %0d pc %h writes %0d addr %h/%h, required ecalls %0d pc %h writes %0d addr %h/000",
                 n, i, o.ecall_cnt, o.ecall_pc, o.wen_cnt, o.addr_c1, o.addr_resp,
                 e.ecall_cnt, e.ecall_pc, e.wen_cnt, e.addr_c1);
      end
      checks++;
      if ((o.both_hi !== 0) || (o.busy_bad !== 0) || (o.stable_bad !== 0) ||
          (o.idle_after !== 1'b1) || (o.ready_at_offer !== 1'b1)) begin
        errors++;
        $display("FAIL rand_%0d_protocol: got overlap %0d busy %0d unstable %0d idle %b offer_ready %b, required 0 0 0 1 1",
                 n, o.both_hi, o.busy_bad, o.stable_bad, o.idle_after, o.ready_at_offer);
      end
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_write_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    while ((got_q.size() > 0) && (exp_q.size() > 0)) begin
      gw = got_q.pop_front();
      ew = exp_q.pop_front();
      checks++;
      if (gw !== ew) begin
        errors++;
        $display("FAIL rand_write_value: got %h, required %h", gw, ew);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.inst      = 32'h0;
    ifc.pc        = 32'h0;
    ifc.rs1_data  = 32'h0;
    ifc.out_ready = 1'b0;
    r_mstatus     = 32'h0;
    r_mtvec       = 32'h0;
    r_mepc        = 32'h0;
    r_mcause      = 32'h0;
    test_reset();
    test_csrrw();
    test_csrrs_x0();
    test_csrrci();
    test_ecall();
    test_mret_hold();
    test_illegal();
    test_reset_in_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Time bound in case the design stops responding
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $fatal(1, "time limit reached");
  end

endmodule
